// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder
//   Single-lane DVI/TMDS receive decoder. Takes 10-bit parallel symbols from a
//   deserializer, finds word alignment with a barrel shifter over two adjacent
//   symbols, and decodes the aligned stream into pixel data, DE and the two
//   control bits. One instance per colour lane.
//
// Ports
//   iCLK     pixel clock, rising edge
//   iRESETn  asynchronous active-low reset
//   iSYM     raw deserialized symbol, bit0 first on the wire
//   oDATA    decoded pixel byte, 0 whenever oDE=0
//   oDE      high when the aligned symbol is a data symbol (only while locked)
//   oCTRL    {C1,C0} of the last decoded control token, held during data
//   oLOCKED  alignment lock status
//   oOFFSET  current bit offset of the alignment window, 0..9
//   oLOST    single-cycle pulse when lock is lost
module tmds_rx_decoder #(
  parameter int unsigned ALIGN_CTRL_COUNT = 16,
  parameter int unsigned SEARCH_WINDOW    = 1024
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  input  logic [9:0] iSYM,
  output logic [7:0] oDATA,
  output logic       oDE,
  output logic [1:0] oCTRL,
  output logic       oLOCKED,
  output logic [3:0] oOFFSET,
  output logic       oLOST
);

  localparam int unsigned CW = $clog2(SEARCH_WINDOW) + 1;

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [CW-1:0] RUN_MAX  = CW'(ALIGN_CTRL_COUNT);
  localparam logic [CW-1:0] RUN_LAST = CW'(ALIGN_CTRL_COUNT - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(SEARCH_WINDOW - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SEARCH_WINDOW - 2);

  logic [0:0]    rState;
  logic [9:0]    rPrev;
  logic [9:0]    rWin;
  logic [3:0]    rOffset;
  logic [CW-1:0] rRun;
  logic [CW-1:0] rWinCnt;
  logic [CW-1:0] rGap;
  logic          rHold;

  logic [19:0]   stream;
  logic [19:0]   shifted;
  logic [9:0]    winNext;
  logic          isCtrl;
  logic [1:0]    ctrlBits;
  logic [7:0]    dBits;
  logic [7:0]    qData;
  logic          lockNow;
  logic          loseNow;
  logic          stepNow;
  logic          liveOut;

  // Older symbol occupies the low half so offset k selects wire bits k..k+9.
  always_comb begin
    stream  = {iSYM, rPrev};
    shifted = stream >> rOffset;
    winNext = shifted[9:0];
  end

  always_comb begin
    isCtrl   = 1'b1;
    ctrlBits = 2'b00;
    case (rWin)
      10'h354: ctrlBits = 2'b00;
      10'h0AB: ctrlBits = 2'b01;
      10'h154: ctrlBits = 2'b10;
      10'h2AB: ctrlBits = 2'b11;
      default: isCtrl   = 1'b0;
    endcase
  end

  always_comb begin
    dBits    = rWin[9] ? ~rWin[7:0] : rWin[7:0];
    qData    = '0;
    qData[0] = dBits[0];
    for (int unsigned i = 1; i < 8; i++) begin
      qData[i] = rWin[8] ? (dBits[i] ^ dBits[i-1]) : ~(dBits[i] ^ dBits[i-1]);
    end
  end

  // Lock / loss fire on the edge where the counter would reach its limit, so
  // oLOCKED rises together with the count of the final required token.
  // rHold masks the single window still built with the previous offset.
  always_comb begin
    lockNow = 1'b0;
    loseNow = 1'b0;
    stepNow = 1'b0;
    if (rState == ST_SEARCH) begin
      lockNow = !rHold && isCtrl && (rRun == RUN_LAST);
      stepNow = !lockNow && (rWinCnt == WIN_LAST);
    end else begin
      loseNow = !isCtrl && (rGap == GAP_LAST);
    end
    liveOut = (rState == ST_LOCKED) && !loseNow;
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      rState  <= ST_SEARCH;
      rPrev   <= '0;
      rWin    <= '0;
      rOffset <= '0;
      rRun    <= '0;
      rWinCnt <= '0;
      rGap    <= '0;
      rHold   <= 1'b0;
      oDATA   <= '0;
      oDE     <= 1'b0;
      oCTRL   <= '0;
      oLOST   <= 1'b0;
    end else begin
      rPrev <= iSYM;
      rWin  <= winNext;
      rHold <= stepNow;
      oLOST <= loseNow;

      if (rState == ST_SEARCH) begin
        if (lockNow) begin
          rState  <= ST_LOCKED;
          rRun    <= '0;
          rWinCnt <= '0;
          rGap    <= '0;
        end else if (stepNow) begin
          rOffset <= (rOffset == 4'd9) ? 4'd0 : rOffset + 4'd1;
          rRun    <= '0;
          rWinCnt <= '0;
        end else begin
          rWinCnt <= rWinCnt + 1'b1;
          if (rHold || !isCtrl) begin
            rRun <= '0;
          end else if (rRun != RUN_MAX) begin
            rRun <= rRun + 1'b1;
          end
        end
      end else begin
        if (loseNow) begin
          rState  <= ST_SEARCH;
          rGap    <= '0;
          rRun    <= '0;
          rWinCnt <= '0;
        end else if (isCtrl) begin
          rGap <= '0;
        end else begin
          rGap <= rGap + 1'b1;
        end
      end

      if (liveOut) begin
        oDE   <= !isCtrl;
        oDATA <= isCtrl ? 8'h00 : qData;
        if (isCtrl) begin
          oCTRL <= ctrlBits;
        end
      end else begin
        oDE   <= 1'b0;
        oDATA <= '0;
        oCTRL <= '0;
      end
    end
  end

  assign oLOCKED = (rState == ST_LOCKED);
  assign oOFFSET = rOffset;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// tb_tmds_rx_decoder
//   Directed self-checking bench for tmds_rx_decoder: reset values, aligned
//   lock and decode, lock boundary, offset search on a rotated stream, lock
//   loss / relock, and asynchronous reset while locked.
module tb_tmds_rx_decoder;

  logic       iCLK = 1'b0;
  logic       iRESETn = 1'b0;
  logic [9:0] iSYM = '0;
  logic [7:0] oDATA;
  logic       oDE;
  logic [1:0] oCTRL;
  logic       oLOCKED;
  logic [3:0] oOFFSET;
  logic       oLOST;

  int nAssert = 0;
  int nFail   = 0;

  always #5 iCLK = ~iCLK;

  tmds_rx_decoder #(
    .ALIGN_CTRL_COUNT(16),
    .SEARCH_WINDOW(1024)
  ) dut (
    .iCLK(iCLK),
    .iRESETn(iRESETn),
    .iSYM(iSYM),
    .oDATA(oDATA),
    .oDE(oDE),
    .oCTRL(oCTRL),
    .oLOCKED(oLOCKED),
    .oOFFSET(oOFFSET),
    .oLOST(oLOST)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a symbol, let the next rising edge sample it, return at the falling edge.
  task automatic tick(input logic [9:0] s);
    iSYM = s;
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic doReset();
    iRESETn = 1'b0;
    @(negedge iCLK);
    @(negedge iCLK);
    iRESETn = 1'b1;
  endtask

  // 800-cycle line: 160 control tokens then 640 data symbols.
  function automatic logic [9:0] lineSym(input int m);
    return ((m % 800) < 160) ? 10'h354 : 10'h1FF;
  endfunction

  // Line pattern, then data only (lock loss), then tokens again (relock).
  function automatic logic [9:0] lossSym(input int m);
    if (m < 3360) return lineSym(m);
    if (m < 4460) return 10'h1FF;
    return 10'h354;
  endfunction

  // Deserializer word slipped by r bits relative to symbol boundaries.
  function automatic logic [9:0] rotSym(input logic [9:0] cur, input logic [9:0] nxt, input int r);
    logic [19:0] p;
    p = {nxt, cur} >> r;
    return p[9:0];
  endfunction

  initial begin
    logic       flag;
    logic       leak;
    logic       idleBad;
    int         lostCount;
    logic [9:0] rot5;

    // ---- reset values ----
    #12;
    check("rst_data",   oDATA,   0);
    check("rst_de",     oDE,     0);
    check("rst_ctrl",   oCTRL,   0);
    check("rst_locked", oLOCKED, 0);
    check("rst_offset", oOFFSET, 0);
    check("rst_lost",   oLOST,   0);
    @(negedge iCLK);
    iRESETn = 1'b1;

    // ---- aligned lock at offset 0, then data ----
    for (int n = 1; n <= 160; n++) begin
      tick(10'h354);
      if (n == 17) check("al_prelock", oLOCKED, 0);
      if (n == 18) begin
        check("al_lock",   oLOCKED, 1);
        check("al_offset", oOFFSET, 0);
        check("al_ctrl",   oCTRL,   2'b00);
      end
      if (n == 19) check("al_tok_de", oDE, 0);
    end
    for (int n = 161; n <= 800; n++) begin
      tick(10'h1FF);
      if (n == 162) check("al_last_tok_de", oDE, 0);
      if (n == 163 || n == 800) begin
        check("al_data_de", oDE,   1);
        check("al_data",    oDATA, 8'h01);
      end
    end

    // ---- decode vectors, each visible two ticks after it is driven ----
    tick(10'h100);
    tick(10'h2FF);
    tick(10'h1FF);
    check("dec_100", oDATA, 8'h00);
    check("dec_100_de", oDE, 1);
    tick(10'h0AB);
    check("dec_2FF", oDATA, 8'hFE);
    tick(10'h154);
    check("dec_1FF", oDATA, 8'h01);
    tick(10'h2AB);
    check("dec_0AB_de", oDE, 0);
    check("dec_0AB_ctrl", oCTRL, 2'b01);
    check("dec_0AB_data", oDATA, 0);
    tick(10'h100);
    check("dec_154_ctrl", oCTRL, 2'b10);
    tick(10'h100);
    check("dec_2AB_ctrl", oCTRL, 2'b11);
    tick(10'h100);
    check("dec_hold_ctrl", oCTRL, 2'b11);
    check("dec_hold_de", oDE, 1);

    // ---- boundary: 15 tokens, 1 data, 15 tokens -> no lock; 16 tokens -> lock ----
    doReset();
    flag = 1'b0;
    for (int n = 1; n <= 53; n++) begin
      if (n == 16 || (n >= 32 && n <= 35)) tick(10'h1FF);
      else tick(10'h354);
      if (n <= 52 && oLOCKED) flag = 1'b1;
    end
    check("bnd_no_early_lock", flag, 0);
    check("bnd_lock16", oLOCKED, 1);

    // ---- offset search on a 7-bit-slipped stream (locks at offset 3), loss, relock ----
    doReset();
    leak      = 1'b0;
    idleBad   = 1'b0;
    lostCount = 0;
    for (int n = 1; n <= 4480; n++) begin
      tick(rotSym(lossSym(n), lossSym(n + 1), 7));
      if (!oLOCKED && (oDATA != 8'h00 || oDE)) leak = 1'b1;
      if (oLOST) lostCount++;
      if (n >= 4383 && n <= 4475 && (oDE || oDATA != 8'h00 || oCTRL != 2'b00)) idleBad = 1'b1;
      if (n == 1023) check("srch_off0", oOFFSET, 0);
      if (n == 1024) check("srch_off1", oOFFSET, 1);
      if (n == 2047) check("srch_off1_hold", oOFFSET, 1);
      if (n == 2048) check("srch_off2", oOFFSET, 2);
      if (n == 3071) check("srch_off2_hold", oOFFSET, 2);
      if (n == 3072) check("srch_off3", oOFFSET, 3);
      if (n == 3215) check("srch_prelock", oLOCKED, 0);
      if (n == 3216) begin
        check("srch_lock", oLOCKED, 1);
        check("srch_lock_off", oOFFSET, 3);
      end
      if (n == 3217) check("srch_tok_de", oDE, 0);
      if (n == 3361) begin
        check("srch_data_de", oDE, 1);
        check("srch_data", oDATA, 8'h01);
      end
      if (n == 4382) begin
        check("loss_pre_locked", oLOCKED, 1);
        check("loss_pre_lost", oLOST, 0);
      end
      if (n == 4383) begin
        check("loss_locked", oLOCKED, 0);
        check("loss_pulse", oLOST, 1);
        check("loss_offset", oOFFSET, 3);
        check("loss_idle_de", oDE, 0);
      end
      if (n == 4384) check("loss_pulse_end", oLOST, 0);
      if (n == 4475) check("relock_pre", oLOCKED, 0);
      if (n == 4476) begin
        check("relock", oLOCKED, 1);
        check("relock_off", oOFFSET, 3);
      end
    end
    check("srch_no_leak", leak, 0);
    check("loss_pulse_count", lostCount, 1);
    check("loss_idle", idleBad, 0);

    // ---- lock at offset 5, then asynchronous reset ----
    doReset();
    rot5 = rotSym(10'h354, 10'h354, 5);
    for (int n = 1; n <= 5140; n++) begin
      tick(rot5);
      if (n == 5120) check("r5_off5", oOFFSET, 5);
      if (n == 5136) check("r5_prelock", oLOCKED, 0);
      if (n == 5137) begin
        check("r5_lock", oLOCKED, 1);
        check("r5_lock_off", oOFFSET, 5);
      end
    end
    #2 iRESETn = 1'b0;
    #1;
    check("arst_locked", oLOCKED, 0);
    check("arst_offset", oOFFSET, 0);
    check("arst_de",     oDE,     0);
    check("arst_data",   oDATA,   0);
    @(negedge iCLK);
    iRESETn = 1'b1;
    flag = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick(rot5);
      if (oLOCKED || oDE || oDATA != 8'h00 || oCTRL != 2'b00 || oOFFSET != 4'd0) flag = 1'b1;
    end
    check("arst_idle_after", flag, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
